// File: rtl/ring_pkg.sv
// Shared types and helpers for the one-hot ring phase monitor.
package ring_pkg;

    // Monitor tracking states
    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        TRACK  = 2'd1,
        LOCKED = 2'd2
    } ring_state_t;

    // Helpers operate on a zero-extended vector so they serve any ring width up to MAX_W
    localparam int MAX_W = 32;

    // Initial ring state: only the MSB of a w-bit ring set
    function automatic logic [MAX_W-1:0] ring_init(input int unsigned w);
        return MAX_W'(1) << (w - 1);
    endfunction

    // Rotate a w-bit ring right by one: {x[0], x[w-1:1]}
    function automatic logic [MAX_W-1:0] rot_right(input logic [MAX_W-1:0] x,
                                                   input int unsigned w);
        return (x >> 1) | (MAX_W'(x[0]) << (w - 1));
    endfunction

    // Exactly one bit set
    function automatic logic onehot(input logic [MAX_W-1:0] x);
        return ($countones(x) == 1);
    endfunction

endpackage

// File: rtl/ring_onehot_check.sv
// Combinational one-hot check and phase encoder for a ring sample.
// Phase index counts from the MSB: MSB=0 ... LSB=WIDTH-1. The index is
// only meaningful when is_onehot is set.
module ring_onehot_check
    import ring_pkg::*;
#(
    parameter int WIDTH = 4,
    localparam int PW = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] ring_in,
    output logic             is_onehot,
    output logic [PW-1:0]    phase_idx
);

    assign is_onehot = onehot(MAX_W'(ring_in));

    // Each index bit is the OR of ring positions whose MSB-relative index has that bit set
    generate
        for (genvar gi = 0; gi < PW; gi++) begin : g_idx_bit
            logic [WIDTH-1:0] sel;
            for (genvar gj = 0; gj < WIDTH; gj++) begin : g_pos
                localparam int POS = WIDTH - 1 - gj;
                assign sel[gj] = ring_in[gj] & POS[gi];
            end
            assign phase_idx[gi] = |sel;
        end
    endgenerate

endmodule

// File: rtl/ring_phase_monitor.sv
// Monitors a right-rotating one-hot ring counter: checks integrity and
// rotation order, locks after LOCK_CNT correct steps, counts revolutions
// and error events. All outputs are registered (one-cycle latency).
module ring_phase_monitor
    import ring_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int LOCK_CNT = 4,
    parameter int REV_W    = 16,
    parameter int ERR_W    = 8,
    localparam int PW = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] ring_in,
    input  logic             clr_err,
    output logic             locked,
    output logic [PW-1:0]    phase,
    output logic             rev_pulse,
    output logic [REV_W-1:0] rev_count,
    output logic             onehot_err,
    output logic             seq_err,
    output logic [ERR_W-1:0] err_count
);

    localparam logic [WIDTH-1:0] RING_INIT = WIDTH'(ring_init(WIDTH));

    ring_state_t      state_reg, state_next;
    logic [WIDTH-1:0] prev_reg, prev_next;
    logic [3:0]       good_cnt_reg, good_cnt_next;
    logic             locked_reg, locked_next;
    logic [PW-1:0]    phase_reg, phase_next;
    logic             rev_pulse_reg, rev_pulse_next;
    logic [REV_W-1:0] rev_count_reg, rev_count_next;
    logic             onehot_err_reg, onehot_err_next;
    logic             seq_err_reg, seq_err_next;
    logic [ERR_W-1:0] err_count_reg, err_count_next;

    logic             in_onehot;
    logic [PW-1:0]    in_phase;
    logic [WIDTH-1:0] ring_rot;
    logic             is_hold;
    logic             is_step;

    ring_onehot_check #(.WIDTH(WIDTH)) u_check (
        .ring_in   (ring_in),
        .is_onehot (in_onehot),
        .phase_idx (in_phase)
    );

    assign ring_rot = WIDTH'(rot_right(MAX_W'(prev_reg), WIDTH));
    assign is_hold  = (ring_in == prev_reg);
    assign is_step  = (ring_in == ring_rot);

    // State and output registers, asynchronously cleared
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= SEARCH;
            prev_reg       <= '0;
            good_cnt_reg   <= '0;
            locked_reg     <= 1'b0;
            phase_reg      <= '0;
            rev_pulse_reg  <= 1'b0;
            rev_count_reg  <= '0;
            onehot_err_reg <= 1'b0;
            seq_err_reg    <= 1'b0;
            err_count_reg  <= '0;
        end else begin
            state_reg      <= state_next;
            prev_reg       <= prev_next;
            good_cnt_reg   <= good_cnt_next;
            locked_reg     <= locked_next;
            phase_reg      <= phase_next;
            rev_pulse_reg  <= rev_pulse_next;
            rev_count_reg  <= rev_count_next;
            onehot_err_reg <= onehot_err_next;
            seq_err_reg    <= seq_err_next;
            err_count_reg  <= err_count_next;
        end
    end

    // Next-state, counters and output pulses for the current sample
    always_comb begin
        state_next      = state_reg;
        prev_next       = prev_reg;
        good_cnt_next   = good_cnt_reg;
        rev_pulse_next  = 1'b0;
        rev_count_next  = rev_count_reg;
        onehot_err_next = 1'b0;
        seq_err_next    = 1'b0;
        err_count_next  = err_count_reg;

        if (in_valid) begin
            if (!in_onehot) begin
                onehot_err_next = 1'b1;
                state_next      = SEARCH;
            end else begin
                case (state_reg)
                    SEARCH: begin
                        prev_next     = ring_in;
                        good_cnt_next = '0;
                        state_next    = TRACK;
                    end
                    TRACK: begin
                        if (is_hold) begin
                            // repeated sample: upstream has not advanced yet
                        end else if (is_step) begin
                            prev_next     = ring_in;
                            good_cnt_next = good_cnt_reg + 4'd1;
                            if (good_cnt_reg + 4'd1 == 4'(LOCK_CNT))
                                state_next = LOCKED;
                        end else begin
                            // out-of-order before lock just restarts the run quietly
                            prev_next     = ring_in;
                            good_cnt_next = '0;
                        end
                    end
                    LOCKED: begin
                        if (is_hold) begin
                            // repeated sample: upstream has not advanced yet
                        end else if (is_step) begin
                            prev_next = ring_in;
                            if (ring_in == RING_INIT) begin
                                rev_pulse_next = 1'b1;
                                rev_count_next = rev_count_reg + REV_W'(1);
                            end
                        end else begin
                            seq_err_next  = 1'b1;
                            prev_next     = ring_in;
                            good_cnt_next = '0;
                            state_next    = TRACK;
                        end
                    end
                    default: state_next = SEARCH;
                endcase
            end
        end

        // Clear wins over a same-cycle error; count saturates
        if (clr_err)
            err_count_next = '0;
        else if ((onehot_err_next || seq_err_next) && (err_count_reg != '1))
            err_count_next = err_count_reg + ERR_W'(1);
    end

    // Registered lock flag and phase: phase tracks prev only while locked
    always_comb begin
        locked_next = (state_next == LOCKED);
        phase_next  = '0;
        if (locked_next)
            phase_next = (prev_next != prev_reg) ? in_phase : phase_reg;
    end

    assign locked     = locked_reg;
    assign phase      = phase_reg;
    assign rev_pulse  = rev_pulse_reg;
    assign rev_count  = rev_count_reg;
    assign onehot_err = onehot_err_reg;
    assign seq_err    = seq_err_reg;
    assign err_count  = err_count_reg;

endmodule

// File: tb/tb_ring_phase_monitor.sv
// Self-checking bench for ring_phase_monitor with a behavioural reference model.
module tb_ring_phase_monitor;

    localparam int WIDTH    = 4;
    localparam int LOCK_CNT = 4;
    localparam int REV_W    = 16;
    localparam int ERR_W    = 8;
    localparam int PW       = 2;
    localparam int REV_MOD  = 1 << REV_W;
    localparam int ERR_MAX  = (1 << ERR_W) - 1;
    localparam int VW       = 1 + PW + 1 + REV_W + 1 + 1 + ERR_W;

    localparam int M_SEARCH = 0;
    localparam int M_TRACK  = 1;
    localparam int M_LOCKED = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic [WIDTH-1:0] ring_in = '0;
    logic             clr_err = 1'b0;
    logic             locked;
    logic [PW-1:0]    phase;
    logic             rev_pulse;
    logic [REV_W-1:0] rev_count;
    logic             onehot_err;
    logic             seq_err;
    logic [ERR_W-1:0] err_count;

    ring_phase_monitor #(
        .WIDTH(WIDTH), .LOCK_CNT(LOCK_CNT), .REV_W(REV_W), .ERR_W(ERR_W)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .ring_in(ring_in),
        .clr_err(clr_err), .locked(locked), .phase(phase),
        .rev_pulse(rev_pulse), .rev_count(rev_count),
        .onehot_err(onehot_err), .seq_err(seq_err), .err_count(err_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: mode, position index of last accepted sample (MSB=0), run length
    int m_mode, m_prev, m_good, m_rev, m_err;
    bit m_rev_pulse, m_oh, m_seq;

    function automatic int pos_of(input logic [WIDTH-1:0] s);
        for (int i = 0; i < WIDTH; i++)
            if (s[WIDTH-1-i]) return i;
        return -1;
    endfunction

    function automatic logic [WIDTH-1:0] ring_at(input int p);
        return WIDTH'(1) << (WIDTH - 1 - p);
    endfunction

    function automatic logic [WIDTH-1:0] bad_sample();
        logic [WIDTH-1:0] s;
        do s = WIDTH'($urandom); while ($countones(s) == 1);
        return s;
    endfunction

    function automatic logic [VW-1:0] dut_vec();
        return {locked, phase, rev_pulse, rev_count, onehot_err, seq_err, err_count};
    endfunction

    function automatic logic [VW-1:0] exp_vec();
        logic lk;
        lk = (m_mode == M_LOCKED);
        return {lk, PW'(lk ? m_prev : 0), m_rev_pulse, REV_W'(m_rev),
                m_oh, m_seq, ERR_W'(m_err)};
    endfunction

    task automatic model_reset();
        m_mode = M_SEARCH; m_prev = 0; m_good = 0; m_rev = 0; m_err = 0;
        m_rev_pulse = 0; m_oh = 0; m_seq = 0;
    endtask

    task automatic model_step(input bit v, input logic [WIDTH-1:0] s, input bit c);
        int p;
        m_rev_pulse = 0; m_oh = 0; m_seq = 0;
        if (v) begin
            if ($countones(s) != 1) begin
                m_oh = 1;
                m_mode = M_SEARCH;
            end else begin
                p = pos_of(s);
                if (m_mode == M_SEARCH) begin
                    m_prev = p; m_good = 0; m_mode = M_TRACK;
                end else if (p == m_prev) begin
                    m_good = m_good;
                end else if (p == (m_prev + 1) % WIDTH) begin
                    m_prev = p;
                    if (m_mode == M_TRACK) begin
                        m_good++;
                        if (m_good == LOCK_CNT) m_mode = M_LOCKED;
                    end else if (p == 0) begin
                        m_rev_pulse = 1;
                        m_rev = (m_rev + 1) % REV_MOD;
                    end
                end else begin
                    if (m_mode == M_LOCKED) m_seq = 1;
                    m_prev = p; m_good = 0; m_mode = M_TRACK;
                end
            end
        end
        if (c) m_err = 0;
        else if ((m_oh || m_seq) && m_err < ERR_MAX) m_err++;
    endtask

    // One clock of stimulus; leaves time at edge+1 so outputs can be sampled
    task automatic drive(input bit v, input logic [WIDTH-1:0] s, input bit c);
        in_valid = v; ring_in = s; clr_err = c;
        @(posedge clk);
        model_step(v, s, c);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; clr_err = 1'b0;
        @(posedge clk);
        #1;
        model_reset();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (dut_vec() !== '0) begin
            n_fail++;
            $display("FAIL reset_state: got %h expected 0", dut_vec());
        end
    endtask

    task automatic test_lock_rev();
        do_reset();
        for (int k = 1; k <= 9; k++) begin
            drive(1'b1, ring_at((k - 1) % WIDTH), 1'b0);
            n_checks++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL lock_rev step %0d: got %h expected %h", k, dut_vec(), exp_vec());
            end
            if (k == 4) begin
                n_checks++;
                if (locked !== 1'b0) begin
                    n_fail++;
                    $display("FAIL early_lock: locked=%b expected 0", locked);
                end
            end
            if (k == 5) begin
                n_checks++;
                if ({locked, rev_pulse, phase} !== {1'b1, 1'b0, 2'd0}) begin
                    n_fail++;
                    $display("FAIL lock_point: locked/rev/phase=%b%b%0d expected 1 0 0",
                             locked, rev_pulse, phase);
                end
            end
            if (k >= 5) begin
                n_checks++;
                if (phase !== PW'((k - 1) % WIDTH)) begin
                    n_fail++;
                    $display("FAIL phase step %0d: got %0d expected %0d", k, phase, (k - 1) % WIDTH);
                end
            end
            if (k == 9) begin
                n_checks++;
                if ({rev_pulse, rev_count} !== {1'b1, 16'd1}) begin
                    n_fail++;
                    $display("FAIL first_rev: pulse=%b count=%0d expected 1 1", rev_pulse, rev_count);
                end
            end
        end
    endtask

    task automatic test_holds();
        bit               v_tab [6] = '{1, 1, 0, 0, 0, 1};
        int               p_tab [6] = '{1, 1, 3, 2, 0, 2};
        logic [WIDTH-1:0] s;
        for (int k = 0; k < 6; k++) begin
            s = v_tab[k] ? ring_at(p_tab[k]) : WIDTH'($urandom);
            drive(v_tab[k], s, 1'b0);
            n_checks++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL holds step %0d: got %h expected %h", k, dut_vec(), exp_vec());
            end
            n_checks++;
            if ({locked, onehot_err, seq_err, phase} !== {3'b100, PW'(k < 5 ? 1 : 2)}) begin
                n_fail++;
                $display("FAIL holds_flags step %0d: lk/oh/seq/phase=%b%b%b%0d expected 1 0 0 %0d",
                         k, locked, onehot_err, seq_err, phase, k < 5 ? 1 : 2);
            end
        end
    endtask

    task automatic test_seq_fault();
        int pre [3] = '{3, 0, 1};
        for (int k = 0; k < 3; k++) drive(1'b1, ring_at(pre[k]), 1'b0);
        drive(1'b1, ring_at(3), 1'b0);
        n_checks++;
        if ({seq_err, err_count, locked} !== {1'b1, 8'd1, 1'b0}) begin
            n_fail++;
            $display("FAIL seq_fault: seq/err/lk=%b %0d %b expected 1 1 0", seq_err, err_count, locked);
        end
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, ring_at(k), 1'b0);
            n_checks++;
            if (dut_vec() !== exp_vec() || locked !== (k == 3)) begin
                n_fail++;
                $display("FAIL relock step %0d: got %h expected %h", k, dut_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_onehot_fault();
        do_reset();
        drive(1'b1, 4'b0000, 1'b0);
        n_checks++;
        if ({onehot_err, err_count} !== {1'b1, 8'd1}) begin
            n_fail++;
            $display("FAIL zero_sample: oh=%b err=%0d expected 1 1", onehot_err, err_count);
        end
        for (int k = 0; k < 5; k++) drive(1'b1, ring_at(k % WIDTH), 1'b0);
        drive(1'b1, 4'b0110, 1'b0);
        n_checks++;
        if ({onehot_err, err_count, locked} !== {1'b1, 8'd2, 1'b0} || dut_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL multi_bit: got %h expected %h", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_saturation();
        for (int k = 0; k < 260; k++) begin
            drive(1'b1, bad_sample(), 1'b0);
            n_checks++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL sat step %0d: got %h expected %h", k, dut_vec(), exp_vec());
            end
        end
        n_checks++;
        if (err_count !== 8'd255) begin
            n_fail++;
            $display("FAIL saturate: err=%0d expected 255", err_count);
        end
        drive(1'b1, bad_sample(), 1'b1);
        n_checks++;
        if ({err_count, onehot_err} !== {8'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL clr_priority: err=%0d oh=%b expected 0 1", err_count, onehot_err);
        end
    endtask

    task automatic test_random();
        int               up;
        int               r;
        logic [WIDTH-1:0] s;
        bit               v;
        bit               c;
        do_reset();
        up = 0;
        for (int k = 0; k < 600; k++) begin
            r = $urandom_range(0, 99);
            v = 1'b1; c = 1'b0;
            if (r < 60) begin
                s = ring_at(up); up = (up + 1) % WIDTH;
            end else if (r < 70) begin
                s = ring_at((up + WIDTH - 1) % WIDTH);
            end else if (r < 80) begin
                v = 1'b0; s = WIDTH'($urandom);
            end else if (r < 86) begin
                up = $urandom_range(0, WIDTH - 1); s = ring_at(up); up = (up + 1) % WIDTH;
            end else if (r < 95) begin
                s = bad_sample();
            end else begin
                s = ring_at(up); up = (up + 1) % WIDTH; c = 1'b1;
            end
            drive(v, s, c);
            n_checks++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL random cyc %0d in=%b v=%b clr=%b: got %h expected %h",
                         k, s, v, c, dut_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int k = 0; k < 17; k++) drive(1'b1, ring_at(k % WIDTH), 1'b0);
        n_checks++;
        if ({locked, rev_count} !== {1'b1, 16'd3}) begin
            n_fail++;
            $display("FAIL pre_reset: lk=%b rev=%0d expected 1 3", locked, rev_count);
        end
        in_valid = 1'b0;
        #3;
        rst = 1'b1;
        #1;
        n_checks++;
        if (dut_vec() !== '0) begin
            n_fail++;
            $display("FAIL async_reset: got %h expected 0", dut_vec());
        end
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, ring_at(k % WIDTH), 1'b0);
            n_checks++;
            if (locked !== (k == 4) || dut_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL post_reset step %0d: got %h expected %h", k, dut_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        test_reset();
        test_lock_rev();
        test_holds();
        test_seq_fault();
        test_onehot_fault();
        test_saturation();
        test_random();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
